// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage <-> HI/LO multiply/divide sequencer handshake and result bus.
interface hilo_muldiv_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [63:0] hl_data;
  logic        hl_we;

  modport master (
    output start, op, src_a, src_b, flush,
    input  stall, busy, hl_data, hl_we
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output stall, busy, hl_data, hl_we
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO write path.
// Multiply is fixed latency; divide is radix-2 restoring, one quotient bit per cycle.
module hilo_muldiv_ctrl #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  hilo_muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [63:0] hl_data_q, hl_data_d;
  logic        busy_q, busy_d;

  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] div_b, rem_next, quo_next, rem_fix, quo_fix;
  logic [32:0] shift_v, trial_v;
  logic        is_signed;

  // Datapath helpers, next-state and register updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    hl_data_d = hl_data_q;

    is_signed = ~op_q[0];
    // Signed multiply is the low 64 bits of the sign-extended product.
    ext_a = {(is_signed ? {32{a_q[31]}} : 32'h0000_0000), a_q};
    ext_b = {(is_signed ? {32{b_q[31]}} : 32'h0000_0000), b_q};
    prod  = ext_a * ext_b;

    // quo_q doubles as the dividend shift register; its MSB feeds the remainder.
    div_b    = (is_signed && b_q[31]) ? (32'h0000_0000 - b_q) : b_q;
    shift_v  = {rem_q, quo_q[31]};
    trial_v  = shift_v - {1'b0, div_b};
    rem_next = trial_v[32] ? shift_v[31:0] : trial_v[31:0];
    quo_next = {quo_q[30:0], ~trial_v[32]};
    quo_fix  = (is_signed && (a_q[31] ^ b_q[31])) ? (32'h0000_0000 - quo_next) : quo_next;
    rem_fix  = (is_signed && a_q[31]) ? (32'h0000_0000 - rem_next) : rem_next;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          a_d  = bus.src_a;
          b_d  = bus.src_b;
          op_d = bus.op;
          if (bus.op[1]) begin
            state_d = S_DIV;
            cnt_d   = 6'd32;
            rem_d   = 32'h0000_0000;
            quo_d   = (!bus.op[0] && bus.src_a[31]) ? (32'h0000_0000 - bus.src_a) : bus.src_a;
          end else begin
            state_d = S_MUL;
            cnt_d   = 6'(MUL_CYCLES);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_q == 6'd1) begin
          state_d   = S_DONE;
          cnt_d     = 6'd0;
          hl_data_d = prod;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DIV: begin
        rem_d = rem_next;
        quo_d = quo_next;
        if (cnt_q == 6'd1) begin
          state_d   = S_DONE;
          cnt_d     = 6'd0;
          hl_data_d = (b_q == 32'h0000_0000) ? {a_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase

    // A flush abandons any operation and leaves the last result untouched.
    if (bus.flush) begin
      state_d   = S_IDLE;
      cnt_d     = 6'd0;
      hl_data_d = hl_data_q;
    end else begin
      hl_data_d = hl_data_d;
    end

    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 2'd0;
      a_q       <= 32'h0000_0000;
      b_q       <= 32'h0000_0000;
      rem_q     <= 32'h0000_0000;
      quo_q     <= 32'h0000_0000;
      hl_data_q <= 64'h0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      hl_data_q <= hl_data_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.stall   = ~rst & ~bus.flush &
                       (((state_q == S_IDLE) & bus.start) | (state_q == S_MUL) | (state_q == S_DIV));
  assign bus.hl_we   = ~rst & ~bus.flush & (state_q == S_DONE);
  assign bus.busy    = busy_q;
  assign bus.hl_data = hl_data_q;

endmodule
